// File: rtl/mac_pkg.sv
// Shared types and helpers for the streaming MAC engine.
// Accumulator width derivation, S1 control record, overflow and saturation selection.
package mac_pkg;

    function automatic int mac_aw(input int dw, input int guard);
        return 2 * dw + guard;
    endfunction

    // Product bits live beside this record so the record stays width-independent.
    typedef struct packed {
        logic last;
        logic valid;
    } s1_ctl_t;

    typedef enum logic [1:0] {
        ADJ_NONE,
        ADJ_MAX,
        ADJ_MIN
    } adj_t;

    function automatic logic mac_ovf(input logic sgn, input logic carry,
                                     input logic acc_msb, input logic add_msb,
                                     input logic sum_msb);
        if (sgn)
            return (acc_msb == add_msb) && (sum_msb != acc_msb);
        return carry;
    endfunction

    // On signed overflow the true sum carries the sign of the addend.
    function automatic adj_t mac_sat_sel(input logic sgn, input logic ovf,
                                         input logic add_msb);
        if (!ovf)
            return ADJ_NONE;
        if (sgn && add_msb)
            return ADJ_MIN;
        return ADJ_MAX;
    endfunction

endpackage

// File: rtl/mac_mult.sv
// Combinational DW x DW multiplier, signed or unsigned per SIGNED.
module mac_mult #(
    parameter int DW     = 8,
    parameter int SIGNED = 0
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] p
);

    logic [2*DW-1:0] ax;
    logic [2*DW-1:0] bx;

    // Extending to full product width first makes the truncated product exact in both modes.
    always_comb begin
        if (SIGNED != 0) begin
            ax = {{DW{a[DW-1]}}, a};
            bx = {{DW{b[DW-1]}}, b};
        end else begin
            ax = {{DW{1'b0}}, a};
            bx = {{DW{1'b0}}, b};
        end
        p = ax * bx;
    end

endmodule

// File: rtl/mac_stream_acc.sv
// Pipelined multiply-accumulate engine with valid/ready on both sides.
// Define MAC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_stream_acc
    import mac_pkg::*;
#(
    parameter int DW     = 8,
    parameter int GUARD  = 4,
    parameter int AW     = mac_aw(DW, GUARD),
    parameter int CW     = 8,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] acc_out,
    output logic [CW-1:0] cnt_out,
    output logic          ovf
);

    logic [2*DW-1:0] prod;
    logic [2*DW-1:0] s1_prod;
    s1_ctl_t         s1;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   ext;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   acc_next;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            ovf_run;
    logic            ovf_this;
    logic            stall;
    logic            accept;

    mac_mult #(.DW(DW), .SIGNED(SIGNED)) u_mult (
        .a (a),
        .b (b),
        .p (prod)
    );

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst & ~clr & ~stall;
    assign accept   = in_valid & in_ready;

    always_comb begin
        if (SIGNED != 0)
            ext = AW'($signed(s1_prod));
        else
            ext = AW'(s1_prod);
        {carry, sum} = {1'b0, acc} + {1'b0, ext};
        ovf_this = mac_ovf(SIGNED != 0, carry, acc[AW-1], ext[AW-1], sum[AW-1]);
        cnt_next = cnt + CW'(1);
    end

`ifdef MAC_SAT_EN
    adj_t adj;

    // Once clamped, the accumulator ignores further addends until the dot product ends.
    always_comb begin
        adj      = mac_sat_sel(SIGNED != 0, ovf_this, ext[AW-1]);
        acc_next = sum;
        if (ovf_run)
            acc_next = acc;
        else if (adj == ADJ_MIN)
            acc_next = {1'b1, {(AW-1){1'b0}}};
        else if (adj == ADJ_MAX)
            acc_next = (SIGNED != 0) ? {1'b0, {(AW-1){1'b1}}} : '1;
    end
`else
    always_comb begin
        acc_next = sum;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            s1_prod   <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf_run   <= 1'b0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            cnt_out   <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            s1.valid  <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf_run   <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            s1.valid <= accept;
            if (accept) begin
                s1_prod <= prod;
                s1.last <= last;
            end
            out_valid <= 1'b0;
            if (s1.valid) begin
                if (s1.last) begin
                    acc_out   <= acc_next;
                    cnt_out   <= cnt_next;
                    ovf       <= ovf_run | ovf_this;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf_run   <= 1'b0;
                end else begin
                    acc     <= acc_next;
                    cnt     <= cnt_next;
                    ovf_run <= ovf_run | ovf_this;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_stream_acc.sv
// Self-checking bench: three parameterisations share one stimulus stream and a dot-product reference model.
module tb_mac_stream_acc;

`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int AWC [3] = '{20, 20, 16};
    localparam bit SGC [3] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst, clr, in_valid, last, out_ready;
    logic [7:0] a, b;
    logic in_ready0, in_ready1, in_ready2;
    logic out_valid0, out_valid1, out_valid2;
    logic [19:0] acc0, acc1;
    logic [15:0] acc2;
    logic [7:0] cnt0, cnt1, cnt2;
    logic ovf0, ovf1, ovf2;

    always #5 clk = ~clk;

    mac_stream_acc #(.DW(8), .GUARD(4), .CW(8), .SIGNED(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .last(last), .out_valid(out_valid0), .out_ready(out_ready),
        .acc_out(acc0), .cnt_out(cnt0), .ovf(ovf0));

    mac_stream_acc #(.DW(8), .GUARD(4), .CW(8), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .last(last), .out_valid(out_valid1), .out_ready(out_ready),
        .acc_out(acc1), .cnt_out(cnt1), .ovf(ovf1));

    mac_stream_acc #(.DW(8), .GUARD(0), .CW(8), .SIGNED(0)) dut_g (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .last(last), .out_valid(out_valid2), .out_ready(out_ready),
        .acc_out(acc2), .cnt_out(cnt2), .ovf(ovf2));

    logic [63:0] oacc [3];
    logic [63:0] ocnt [3];
    logic        oovf [3];
    logic        ordy [3];
    logic        ovld [3];
    assign oacc[0] = 64'(acc0);
    assign oacc[1] = 64'(acc1);
    assign oacc[2] = 64'(acc2);
    assign ocnt[0] = 64'(cnt0);
    assign ocnt[1] = 64'(cnt1);
    assign ocnt[2] = 64'(cnt2);
    assign oovf[0] = ovf0;
    assign oovf[1] = ovf1;
    assign oovf[2] = ovf2;
    assign ordy[0] = in_ready0;
    assign ordy[1] = in_ready1;
    assign ordy[2] = in_ready2;
    assign ovld[0] = out_valid0;
    assign ovld[1] = out_valid1;
    assign ovld[2] = out_valid2;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    typedef struct packed {
        logic [2:0][63:0] acc;
        logic [2:0]       ovf;
        logic [31:0]      cnt;
    } res_t;

    res_t       q[$];
    longint     macc [3];
    bit         movf [3];
    bit         msat [3];
    int         mcnt;
    bit         pend_v;
    logic [7:0] pend_a, pend_b;
    bit         pend_last;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            macc[i] = 0;
            movf[i] = 1'b0;
            msat[i] = 1'b0;
        end
        mcnt   = 0;
        pend_v = 1'b0;
        q.delete();
    endtask

    // Exact integer dot product, folded into each configuration's representable range.
    task automatic model_add(input logic [7:0] pa, input logic [7:0] pb, input bit pl);
        longint p, full, lo, hi, span;
        res_t r;
        for (int i = 0; i < 3; i++) begin
            span = longint'(1) << AWC[i];
            if (SGC[i]) begin
                p  = longint'($signed(pa)) * longint'($signed(pb));
                lo = -(span / 2);
                hi = span / 2 - 1;
            end else begin
                p  = longint'(pa) * longint'(pb);
                lo = 0;
                hi = span - 1;
            end
            if (!(SAT && msat[i])) begin
                full = macc[i] + p;
                if (full > hi || full < lo) begin
                    movf[i] = 1'b1;
                    if (SAT) begin
                        macc[i] = (full > hi) ? hi : lo;
                        msat[i] = 1'b1;
                    end else begin
                        macc[i] = (full > hi) ? full - span : full + span;
                    end
                end else begin
                    macc[i] = full;
                end
            end
        end
        mcnt = (mcnt + 1) % 256;
        if (pl) begin
            r = '0;
            for (int i = 0; i < 3; i++) begin
                r.acc[i] = 64'(macc[i] & ((longint'(1) << AWC[i]) - 1));
                r.ovf[i] = movf[i];
                macc[i] = 0;
                movf[i] = 1'b0;
                msat[i] = 1'b0;
            end
            r.cnt = 32'(mcnt);
            mcnt  = 0;
            q.push_back(r);
        end
    endtask

    always @(negedge clk) begin
        bit   exp_rdy;
        res_t r;
        if (rst) begin
            model_clear();
            check("rdy_in_rst", 64'(in_ready0), 64'd0);
            check("vld_in_rst", 64'(out_valid0), 64'd0);
        end else begin
            exp_rdy = !clr && !(q.size() != 0 && !out_ready);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("in_ready%0d", i), 64'(ordy[i]), 64'(exp_rdy));
                check($sformatf("out_valid%0d", i), 64'(ovld[i]), 64'(q.size() != 0));
            end
            if (q.size() != 0 && out_ready) begin
                r = q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("sb_acc%0d", i), oacc[i], r.acc[i]);
                    check($sformatf("sb_cnt%0d", i), ocnt[i], 64'(r.cnt));
                    check($sformatf("sb_ovf%0d", i), 64'(oovf[i]), 64'(r.ovf[i]));
                end
            end
            if (clr) begin
                model_clear();
            end else if (exp_rdy) begin
                if (pend_v)
                    model_add(pend_a, pend_b, pend_last);
                pend_v    = in_valid;
                pend_a    = a;
                pend_b    = b;
                pend_last = last;
            end
        end
    end

    task automatic send(input logic [7:0] va, input logic [7:0] vb, input bit vl);
        int n;
        n        = 0;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        last     = vl;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready0 && n < 50);
        if (!in_ready0)
            check("send_timeout", 64'(in_ready0), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input longint e0, input longint e1,
                              input longint e2, input int ec,
                              input bit o0, input bit o1, input bit o2);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid0 && n < 50);
        check({tag, "_vld"}, 64'(out_valid0), 64'd1);
        check({tag, "_acc0"}, 64'(acc0), 64'(e0));
        check({tag, "_acc1"}, 64'(acc1), 64'(e1));
        check({tag, "_acc2"}, 64'(acc2), 64'(e2));
        check({tag, "_cnt"}, 64'(cnt0), 64'(ec));
        check({tag, "_ovf0"}, 64'(ovf0), 64'(o0));
        check({tag, "_ovf1"}, 64'(ovf1), 64'(o1));
        check({tag, "_ovf2"}, 64'(ovf2), 64'(o2));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; last = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready0), 64'd0);
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_acc", 64'(acc0), 64'd0);
        check("rst_cnt", 64'(cnt0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(in_ready0), 64'd1);

        // two-pair dot product and its latency
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b1);
        @(negedge clk);
        check("lat_early", 64'(out_valid0), 64'd0);
        @(negedge clk);
        check("lat_k1", 64'(out_valid0), 64'd1);
        check("dp42_acc", 64'(acc0), 64'd42);
        check("dp42_cnt", 64'(cnt0), 64'd2);
        check("dp42_ovf", 64'(ovf0), 64'd0);
        @(posedge clk);
        #1;

        // back-pressure with a held input, then back-to-back results
        out_ready = 1'b0;
        send(8'd1, 8'd2, 1'b1);
        send(8'd4, 8'd4, 1'b1);
        in_valid = 1'b1; a = 8'd3; b = 8'd3; last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready", 64'(in_ready0), 64'd0);
            check("stall_acc", 64'(acc0), 64'd2);
            check("stall_cnt", 64'(cnt0), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("b2b_acc_a", 64'(acc0), 64'd2);
        check("b2b_ready", 64'(in_ready0), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_vld_b", 64'(out_valid0), 64'd1);
        check("b2b_acc_b", 64'(acc0), 64'd16);
        @(negedge clk);
        check("b2b_vld_c", 64'(out_valid0), 64'd1);
        check("b2b_acc_c", 64'(acc0), 64'd9);
        @(negedge clk);
        check("b2b_idle", 64'(out_valid0), 64'd0);
        @(posedge clk);
        #1;

        // accumulator overflow at full scale
        send(8'hFF, 8'hFF, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        expect_res("ovf", 130050, 2, SAT ? 65535 : 64514, 2, 1'b0, 1'b0, 1'b1);

        // signed single-pair product
        send(8'hFD, 8'd7, 1'b1);
        expect_res("sgn", 1771, 20'hFFFEB, 1771, 1, 1'b0, 1'b0, 1'b0);

        // flush after two of three pairs
        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd3, 1'b0);
        clr = 1'b1; in_valid = 1'b1; a = 8'd9; b = 8'd9; last = 1'b1;
        @(negedge clk);
        check("clr_ready", 64'(in_ready0), 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0;
        send(8'd2, 8'd2, 1'b1);
        expect_res("clr", 4, 4, 4, 1, 1'b0, 1'b0, 1'b0);

        // reset with S1 busy and a result pending
        out_ready = 1'b0;
        send(8'd5, 8'd5, 1'b1);
        send(8'd6, 8'd6, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 64'(out_valid0), 64'd0);
        check("mid_rst_vld_s", 64'(out_valid1), 64'd0);
        check("mid_rst_acc", 64'(acc0), 64'd0);
        check("mid_rst_cnt", 64'(cnt0), 64'd0);
        check("mid_rst_ovf", 64'(ovf0), 64'd0);
        check("mid_rst_ready", 64'(in_ready0), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'd1, 8'd1, 1'b1);
        expect_res("post_rst", 1, 1, 1, 1, 1'b0, 1'b0, 1'b0);

        // count wraps at 2^CW: 260 pairs report 4
        for (int i = 0; i < 259; i++)
            send(8'($urandom), 8'($urandom), 1'b0);
        send(8'($urandom), 8'($urandom), 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid0 && n < 50);
        check("cnt_wrap", 64'(cnt0), 64'd4);
        @(posedge clk);
        #1;

        // random traffic with random back-pressure and occasional flushes
        repeat (800) begin
            in_valid  = ($urandom_range(9) < 7);
            a         = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            b         = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            last      = ($urandom_range(3) == 0);
            out_ready = ($urandom_range(3) != 0);
            clr       = ($urandom_range(49) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
